// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl -- interrupt / WFI / MRET control for a single-hart in-order core.
//
// Sequences interrupt entry, wait-for-interrupt and return-from-trap. The
// controller sits beside the EX stage: it watches the instruction in EX, the
// synchronized interrupt lines and the CSR enable bits. It freezes or flushes
// the front of the pipe and overrides the PC when a trap is taken or an MRET
// retires.
//
// Optional feature (compile-time macro):
//   TRAP_CTRL_TIMER_INT_EN  defined   -> the timer interrupt path is built
//                                        (synchronizer, pending bit, cause 7).
//                           undefined -> irq_timer_i / mie_mtie_i are ignored,
//                                        mip_mtip_o is tied to 0 and only the
//                                        external cause (32'h8000_000B) is used.
//
// Ports:
//   clk_i            core clock, rising-edge active
//   rst_i            asynchronous active-high reset
//   pc_i             address of the instruction currently in EX
//   is_wfi_i         WFI decoded in EX (one-cycle valid)
//   is_mret_i        MRET decoded in EX (one-cycle valid)
//   irq_ext_i        external interrupt line, asynchronous, level-sensitive
//   irq_timer_i      timer interrupt line, level-sensitive
//   mstatus_mie_i    global interrupt enable
//   mie_meie_i       external interrupt enable
//   mie_mtie_i       timer interrupt enable
//   mepc_in_i        current mepc, MRET return target
//   stall_o          freeze IF/ID/EX
//   flush_o          kill IF/ID/EX contents this cycle
//   redirect_o       PC override valid
//   redirect_pc_o    PC override target
//   mepc_we_o        mepc write strobe
//   mepc_wdata_o     mepc write data
//   mcause_o         cause of the last trap taken (registered)
//   trap_enter_o     one-cycle strobe: mstatus MPIE<=MIE, MIE<=0
//   mret_done_o      one-cycle strobe: mstatus MIE<=MPIE, MPIE<=1
//   mip_meip_o       synchronized external pending bit
//   mip_mtip_o       synchronized timer pending bit
// -----------------------------------------------------------------------------
module trap_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_i,
   input  logic        is_wfi_i,
   input  logic        is_mret_i,
   input  logic        irq_ext_i,
   input  logic        irq_timer_i,
   input  logic        mstatus_mie_i,
   input  logic        mie_meie_i,
   input  logic        mie_mtie_i,
   input  logic [31:0] mepc_in_i,
   output logic        stall_o,
   output logic        flush_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o,
   output logic        mepc_we_o,
   output logic [31:0] mepc_wdata_o,
   output logic [31:0] mcause_o,
   output logic        trap_enter_o,
   output logic        mret_done_o,
   output logic        mip_meip_o,
   output logic        mip_mtip_o
);

   localparam logic [31:0] TrapVector  = 32'h0001_0000;
   localparam logic [31:0] CauseExt    = 32'h8000_000B;
   localparam logic [31:0] CauseTimer  = 32'h8000_0007;
   localparam logic [31:0] InstrBytes  = 32'd4;

   typedef enum logic [1:0] {
      StRun,
      StWfiWait,
      StTrap,
      StMret
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] mcause_q, mcause_d;

   // --------------------------------------------------------------------------
   // Interrupt synchronizers
   // --------------------------------------------------------------------------
   logic ext_meta_q, ext_sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ext_meta_q <= 1'b0;
         ext_sync_q <= 1'b0;
      end else begin
         ext_meta_q <= irq_ext_i;
         ext_sync_q <= ext_meta_q;
      end
   end

   logic ext_pend;
   logic tmr_pend;

   assign ext_pend   = ext_sync_q & mie_meie_i;
   assign mip_meip_o = ext_sync_q;

`ifdef TRAP_CTRL_TIMER_INT_EN
   logic tmr_meta_q, tmr_sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmr_meta_q <= 1'b0;
         tmr_sync_q <= 1'b0;
      end else begin
         tmr_meta_q <= irq_timer_i;
         tmr_sync_q <= tmr_meta_q;
      end
   end

   assign tmr_pend   = tmr_sync_q & mie_mtie_i;
   assign mip_mtip_o = tmr_sync_q;
`else
   // Timer path not built: inputs kept on the port list but deliberately unused.
   logic unused_timer;
   assign unused_timer = irq_timer_i ^ mie_mtie_i;
   assign tmr_pend     = 1'b0;
   assign mip_mtip_o   = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // Trap decision
   // --------------------------------------------------------------------------
   logic        wake;
   logic        take;
   logic [31:0] trap_cause;

   // wake ignores the global enable so WFI can resume with interrupts masked.
   assign wake       = ext_pend | tmr_pend;
   assign take       = mstatus_mie_i & wake;
   // External interrupt has priority when both are pending.
   assign trap_cause = ext_pend ? CauseExt : CauseTimer;

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StRun;
         epc_q    <= 32'h0;
         mcause_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         epc_q    <= epc_d;
         mcause_q <= mcause_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next state
   // --------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      epc_d    = epc_q;
      mcause_d = mcause_q;
      case (state_q)
         StRun: begin
            // A pending interrupt beats MRET/WFI in EX; that instruction is
            // flushed and re-executed after the handler returns.
            if (take) begin
               state_d  = StTrap;
               epc_d    = pc_i;
               mcause_d = trap_cause;
            end else if (is_mret_i) begin
               state_d = StMret;
            end else if (is_wfi_i) begin
               state_d = StWfiWait;
               epc_d   = pc_i + InstrBytes;  // resume after the WFI, wraps mod 2^32
            end
         end
         StWfiWait: begin
            if (wake) begin
               if (mstatus_mie_i) begin
                  state_d  = StTrap;
                  mcause_d = trap_cause;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StTrap:  state_d = StRun;
         StMret:  state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   // --------------------------------------------------------------------------
   // Outputs: pure decodes of the current state
   // --------------------------------------------------------------------------
   always_comb begin
      stall_o       = 1'b0;
      flush_o       = 1'b0;
      redirect_o    = 1'b0;
      redirect_pc_o = 32'h0;
      mepc_we_o     = 1'b0;
      trap_enter_o  = 1'b0;
      mret_done_o   = 1'b0;
      case (state_q)
         StWfiWait: begin
            stall_o = 1'b1;
         end
         StTrap: begin
            flush_o       = 1'b1;
            redirect_o    = 1'b1;
            redirect_pc_o = TrapVector;
            mepc_we_o     = 1'b1;
            trap_enter_o  = 1'b1;
         end
         StMret: begin
            flush_o       = 1'b1;
            redirect_o    = 1'b1;
            redirect_pc_o = mepc_in_i;
            mret_done_o   = 1'b1;
         end
         default: ;
      endcase
   end

   assign mepc_wdata_o = epc_q;
   assign mcause_o     = mcause_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl -- self-checking bench for trap_ctrl.
// Directed vector table, hand-written reset/timer sequences, then random
// stimulus checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        is_wfi, is_mret;
   logic        irq_ext, irq_timer;
   logic        mstatus_mie, mie_meie, mie_mtie;
   logic [31:0] mepc_in;
   logic        stall, flush, redirect, mepc_we, trap_enter, mret_done;
   logic        mip_meip, mip_mtip;
   logic [31:0] redirect_pc, mepc_wdata, mcause;

   int n_asserts = 0;
   int n_fail    = 0;

   trap_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .pc_i          (pc),
      .is_wfi_i      (is_wfi),
      .is_mret_i     (is_mret),
      .irq_ext_i     (irq_ext),
      .irq_timer_i   (irq_timer),
      .mstatus_mie_i (mstatus_mie),
      .mie_meie_i    (mie_meie),
      .mie_mtie_i    (mie_mtie),
      .mepc_in_i     (mepc_in),
      .stall_o       (stall),
      .flush_o       (flush),
      .redirect_o    (redirect),
      .redirect_pc_o (redirect_pc),
      .mepc_we_o     (mepc_we),
      .mepc_wdata_o  (mepc_wdata),
      .mcause_o      (mcause),
      .trap_enter_o  (trap_enter),
      .mret_done_o   (mret_done),
      .mip_meip_o    (mip_meip),
      .mip_mtip_o    (mip_mtip)
   );

   always #5 clk = ~clk;

   // {stall, flush, redirect, mepc_we, trap_enter, mret_done, mip_meip}
   logic [6:0] dut_flags;
   assign dut_flags = {stall, flush, redirect, mepc_we, trap_enter, mret_done, mip_meip};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_asserts++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural reference model
   // ---------------------------------------------------------------------------
   localparam int ModeRun = 0, ModeWfi = 1, ModeTrap = 2, ModeMret = 3;

   int          m_mode;
   logic [31:0] m_epc, m_mcause;
   logic        ext_hist[$];
   logic        tmr_hist[$];

   // Pending bit seen by the core = line value sampled two edges ago.
   function automatic logic delayed(input logic q[$]);
      return (q.size() >= 2) ? q[1] : 1'b0;
   endfunction

   task automatic model_reset();
      m_mode   = ModeRun;
      m_epc    = 32'h0;
      m_mcause = 32'h0;
      ext_hist.delete();
      tmr_hist.delete();
   endtask

   // Called just after a rising edge; inputs still hold the pre-edge values.
   task automatic model_step();
      logic ep, tp, wk;
      ep = delayed(ext_hist) & mie_meie;
`ifdef TRAP_CTRL_TIMER_INT_EN
      tp = delayed(tmr_hist) & mie_mtie;
`else
      tp = 1'b0;
`endif
      wk = ep | tp;
      case (m_mode)
         ModeRun: begin
            if (wk && mstatus_mie) begin
               m_mode = ModeTrap; m_epc = pc; m_mcause = ep ? 32'h8000_000B : 32'h8000_0007;
            end else if (is_mret) m_mode = ModeMret;
            else if (is_wfi) begin
               m_mode = ModeWfi; m_epc = pc + 32'd4;
            end
         end
         ModeWfi: begin
            if (wk && mstatus_mie) begin
               m_mode = ModeTrap; m_mcause = ep ? 32'h8000_000B : 32'h8000_0007;
            end else if (wk) m_mode = ModeRun;
         end
         default: m_mode = ModeRun;
      endcase
      ext_hist.push_front(irq_ext);
      tmr_hist.push_front(irq_timer);
      if (ext_hist.size() > 2) void'(ext_hist.pop_back());
      if (tmr_hist.size() > 2) void'(tmr_hist.pop_back());
   endtask

   task automatic model_check(input string tag);
      logic       is_trap, is_mr;
      logic [6:0] ef;
      logic       exp_mtip;
      is_trap = (m_mode == ModeTrap);
      is_mr   = (m_mode == ModeMret);
      ef = {m_mode == ModeWfi, is_trap | is_mr, is_trap | is_mr, is_trap, is_trap, is_mr,
            delayed(ext_hist)};
`ifdef TRAP_CTRL_TIMER_INT_EN
      exp_mtip = delayed(tmr_hist);
`else
      exp_mtip = 1'b0;
`endif
      chk({tag, ".flags"}, {25'h0, dut_flags}, {25'h0, ef});
      chk({tag, ".mcause"}, mcause, m_mcause);
      chk({tag, ".mip_mtip"}, {31'h0, mip_mtip}, {31'h0, exp_mtip});
      if (is_trap) begin
         chk({tag, ".redirect_pc"}, redirect_pc, 32'h0001_0000);
         chk({tag, ".mepc_wdata"}, mepc_wdata, m_epc);
      end
      if (is_mr) chk({tag, ".redirect_pc"}, redirect_pc, mepc_in);
   endtask

   // ---------------------------------------------------------------------------
   // Directed vector table
   // ---------------------------------------------------------------------------
   typedef struct {
      logic        irq, mie, meie, wfi, mret;
      logic [31:0] pc;
      logic [6:0]  flags;  // stall,flush,redirect,mepc_we,trap_enter,mret_done,mip_meip
      logic [31:0] rpc, wdata, cause;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic irq, input logic mie, input logic wfi,
                               input logic mret, input logic [31:0] p, input logic [6:0] f,
                               input logic [31:0] rpc, input logic [31:0] wd,
                               input logic [31:0] c);
      vec_t v;
      v.irq = irq; v.mie = mie; v.meie = 1'b1; v.wfi = wfi; v.mret = mret; v.pc = p;
      v.flags = f; v.rpc = rpc; v.wdata = wd; v.cause = c;
      return v;
   endfunction

   localparam logic [31:0] CB = 32'h8000_000B;
   localparam logic [31:0] TV = 32'h0001_0000;

   initial begin
      clk = 1'b0; rst = 1'b1;
      pc = 32'h100; is_wfi = 1'b0; is_mret = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0;
      mstatus_mie = 1'b1; mie_meie = 1'b1; mie_mtie = 1'b0; mepc_in = 32'h204;

      // Reset state
      #1;
      chk("reset.flags", {25'h0, dut_flags}, 32'h0);
      chk("reset.mcause", mcause, 32'h0);
      chk("reset.mip_mtip", {31'h0, mip_mtip}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      //            irq  mie  wfi  mret pc            flags       rpc     wdata         cause
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 7'b0000000, 32'h0, 32'h0, 32'h0));
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 7'b0000000, 32'h0, 32'h0, 32'h0));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 7'b0000001, 32'h0, 32'h0, 32'h0));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 7'b0111100, TV, 32'h100, CB));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 7'b0000000, 32'h0, 32'h0, CB));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 7'b0110010, 32'h204, 32'h0, CB));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 7'b0000000, 32'h0, 32'h0, CB));
      // WFI with interrupts masked: wake returns to RUN without a trap
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 7'b1000000, 32'h0, 32'h0, CB));
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 7'b1000000, 32'h0, 32'h0, CB));
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 7'b1000001, 32'h0, 32'h0, CB));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 7'b0000001, 32'h0, 32'h0, CB));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 7'b0000000, 32'h0, 32'h0, CB));
      // WFI at the top of memory: epc wraps to 0
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 7'b1000000, 32'h0, 32'h0, CB));
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 7'b1000000, 32'h0, 32'h0, CB));
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 7'b1000001, 32'h0, 32'h0, CB));
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 7'b0111101, TV, 32'h0, CB));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 7'b0000001, 32'h0, 32'h0, CB));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 7'b0000000, 32'h0, 32'h0, CB));
      // Interrupt coincides with MRET in EX: trap wins, epc = MRET's pc
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 7'b0000000, 32'h0, 32'h0, CB));
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 7'b0000001, 32'h0, 32'h0, CB));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 7'b0111101, TV, 32'h300, CB));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 7'b0000000, 32'h0, 32'h0, CB));

      for (int i = 0; i < tbl.size(); i++) begin
         irq_ext = tbl[i].irq; mstatus_mie = tbl[i].mie; mie_meie = tbl[i].meie;
         is_wfi = tbl[i].wfi; is_mret = tbl[i].mret; pc = tbl[i].pc;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d.flags", i), {25'h0, dut_flags}, {25'h0, tbl[i].flags});
         chk($sformatf("vec%0d.mcause", i), mcause, tbl[i].cause);
         if (tbl[i].flags[4]) chk($sformatf("vec%0d.rpc", i), redirect_pc, tbl[i].rpc);
         if (tbl[i].flags[3]) chk($sformatf("vec%0d.wdata", i), mepc_wdata, tbl[i].wdata);
      end
      is_wfi = 1'b0; is_mret = 1'b0;

      // Timer line alone with both enables set
      irq_timer = 1'b1; mie_mtie = 1'b1; mstatus_mie = 1'b1; irq_ext = 1'b0;
      repeat (3) @(negedge clk);
`ifdef TRAP_CTRL_TIMER_INT_EN
      chk("timer.trap", {31'h0, trap_enter}, 32'h1);
      chk("timer.mcause", mcause, 32'h8000_0007);
`else
      chk("timer.no_trap", {25'h0, dut_flags}, 32'h0);
      chk("timer.mip_mtip", {31'h0, mip_mtip}, 32'h0);
      chk("timer.mcause", mcause, CB);
`endif
      irq_timer = 1'b0; mie_mtie = 1'b0; mstatus_mie = 1'b0;
      repeat (3) @(negedge clk);

      // Reset in the middle of WFI_WAIT
      mstatus_mie = 1'b1; is_wfi = 1'b1; pc = 32'h200;
      @(negedge clk);
      is_wfi = 1'b0;
      chk("rstwfi.stall_before", {31'h0, stall}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("rstwfi.async_flags", {25'h0, dut_flags}, 32'h0);
      chk("rstwfi.async_mcause", mcause, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rstwfi.after%0d", i), {25'h0, dut_flags}, 32'h0);
      end

      // Random stimulus against the model, with occasional resets
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] r;
         rst = ($urandom_range(0, 99) == 0);
         if (rst) model_reset();
         if ($urandom_range(0, 5) == 0) irq_ext = ~irq_ext;
         if ($urandom_range(0, 5) == 0) irq_timer = ~irq_timer;
         mstatus_mie = ($urandom_range(0, 3) != 0);
         mie_meie    = ($urandom_range(0, 3) != 0);
         mie_mtie    = ($urandom_range(0, 3) != 0);
         r = 4'($urandom_range(0, 15));
         is_wfi  = (r == 4'd0) || (r == 4'd1);
         is_mret = (r == 4'd2) || (r == 4'd3);
         pc      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom, 2'b00} >> 0;
         mepc_in = $urandom;
         @(posedge clk);
         if (!rst) model_step();
         @(negedge clk);
         model_check($sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 clk  input  1  core clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 pc  input  32  address of the instruction currently in EX.
REQ-004 is_wfi / is_mret  input  1 each  WFI / MRET decoded in EX, valid for one cycle.
REQ-005 irq_ext  input  1  asynchronous external interrupt line, level-sensitive.
REQ-006 irq_timer  input  1  timer interrupt line, level-sensitive; used only under TIMER_INT_EN.
REQ-007 mstatus_mie, mie_meie, mie_mtie  input  1 each  current CSR enable bits.
REQ-008 mepc_in  input  32  current mepc value, used for MRET.
REQ-009 stall  output  1  freezes IF/ID/EX while high.
REQ-010 flush  output  1  kills IF/ID/EX contents this cycle.
REQ-011 redirect, redirect_pc  output  1, 32  PC override, valid when redirect=1.
REQ-012 mepc_we, mepc_wdata  output  1, 32  mepc write strobe and data.
REQ-013 mcause  output  32  cause of the last trap taken, registered.
REQ-014 trap_enter / mret_done  output  1 each  one-cycle strobes: mstatus MPIE<=MIE, MIE<=0 / MIE<=MPIE, MPIE<=1.
REQ-015 mip_meip, mip_mtip  output  1 each  synchronized pending bits.

Function
REQ-016 irq_ext and irq_timer each pass through a 2-flop synchronizer; mip_* equal the second flop; a level change is visible on mip_* exactly 2 cycles after the sampling edge.
REQ-017 States: RUN, WFI_WAIT, TRAP, MRET; encoding is free.
REQ-018 take = mstatus_mie & ((mip_meip & mie_meie) | (mip_mtip & mie_mtie)); wake = (mip_meip & mie_meie) | (mip_mtip & mie_mtie).
REQ-019 RUN priority: take -> TRAP (epc<=pc); else is_mret -> MRET; else is_wfi -> WFI_WAIT (epc<=pc+4); else stay.
REQ-020 WFI_WAIT: stall=1; wake & mstatus_mie -> TRAP with latched epc; wake & ~mstatus_mie -> RUN, stall drops, no flush, no redirect; else stay.
REQ-021 TRAP (exactly one cycle): flush=1, redirect=1, redirect_pc=32'h0001_0000, mepc_we=1, mepc_wdata=epc, trap_enter=1, mcause updated; next RUN.
REQ-022 mcause: 32'h8000_000B if external caused trap, else 32'h8000_0007; external wins when both pending.
REQ-023 MRET (exactly one cycle): flush=1, redirect=1, redirect_pc=mepc_in, mret_done=1; next RUN; interrupts re-evaluated from the following cycle.
REQ-024 Simultaneous take and is_mret/is_wfi in RUN: the trap is taken and the MRET/WFI is discarded (flushed, re-executed after return).
REQ-025 In RUN with no event, all strobes (flush, redirect, mepc_we, trap_enter, mret_done) and stall are 0.
REQ-026 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-027 All outputs other than mcause and mip_* are combinational decodes of state only.

Reset
REQ-028 rst=1 forces state RUN, both synchronizer stages 0, epc 0, mcause 0, immediately and without waiting for clk.
REQ-029 Reset asserted in WFI_WAIT, TRAP or MRET abandons the operation; no mepc_we, trap_enter or mret_done pulse appears on or after reset.
REQ-030 First trap possible no earlier than 2 cycles after rst deassertion (synchronizer fill).

Configuration
REQ-031 Macro TRAP_CTRL_TIMER_INT_EN: defined -> timer path per REQ-016..REQ-022; undefined -> irq_timer and mie_mtie ports remain but are ignored, mip_mtip is constant 0, no timer synchronizer flops, mcause only 32'h8000_000B.

Verification
REQ-032 mstatus_mie=1, mie_meie=1, pc=32'h100, pulse irq_ext high -> 2 cycles later TRAP: mepc_wdata=32'h100, redirect_pc=32'h0001_0000, mcause=32'h8000_000B, trap_enter 1 cycle.
REQ-033 is_wfi at pc=32'h200, mie_meie=1, mstatus_mie=1, irq_ext raised 5 cycles later -> stall high throughout, then TRAP with mepc_wdata=32'h204.
REQ-034 Same as REQ-033 with mstatus_mie=0 -> exits to RUN, stall falls, no flush, no mepc_we.
REQ-035 is_mret with mepc_in=32'h204 -> one cycle flush, redirect_pc=32'h204, mret_done=1, back to RUN.
REQ-036 TIMER_INT_EN defined, irq_ext and irq_timer raised together, both enabled -> mcause=32'h8000_000B; with macro undefined, irq_timer alone -> no trap, mip_mtip=0.
REQ-037 rst asserted mid-WFI_WAIT -> stall=0 immediately, state RUN, no strobes after release.
